fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one 8-bit, 16-entry synchronous FIFO write port among NREQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST beats, then moves on.
- Drives the FIFO's wr_en/data_in directly and obeys the FIFO's full flag; the read side is not touched.
- Sits between the producer blocks and the shared FIFO instance.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// FIFO geometry is common with the shared FIFO instance.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef logic [2:0] id_t;
  typedef logic [$clog2(FIFO_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer / FIFO-write bundle for the write arbiter.
// slave: arbiter side; master: producers + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = FIFO_DW
);

  logic            arb_en;
  logic [NREQ-1:0] req_mask;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  id_t             grant_id;
  logic            busy;

  modport slave (
    input  arb_en, req_mask, req_valid,
    input  req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en,
    output fifo_data_in, grant_id, busy
  );

  modport master (
    output arb_en, req_mask, req_valid,
    output req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en,
    input  fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set bit of elig at or above ptr, wrapping.
// Ports: elig (candidates), ptr (start index) -> idx, found.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] elig,
  input  id_t             ptr,
  output id_t             idx,
  output logic            found
);

  // Smallest distance from ptr (mod NREQ) wins.
  always_comb begin
    int best;
    int off;
    idx   = '0;
    found = 1'b0;
    best  = NREQ;
    off   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(ptr)) off = i - int'(ptr);
      else                off = i + NREQ - int'(ptr);
      if (elig[i] && off < best) begin
        best  = off;
        idx   = id_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port.
// Ports: clk, rst (async high), bus (slave: producers in, FIFO write out).
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  state_t state, state_nxt;
  id_t    owner, owner_nxt;
  id_t    rr_ptr, rr_nxt;
  cnt_t   cnt, cnt_nxt;

  id_t             pick;
  logic            found;
  logic [NREQ-1:0] own_oh;
  logic            own_valid;
  logic            own_mask;
  logic            own_last;
  logic            accept;
  logic            done;
  logic [DW-1:0]   data_mux;

  fifo_wr_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .elig  (bus.req_valid & ~bus.req_mask),
    .ptr   (rr_ptr),
    .idx   (pick),
    .found (found)
  );

  assign own_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign own_valid = |(bus.req_valid & own_oh);
  assign own_mask  = |(bus.req_mask & own_oh);
  assign own_last  = |(bus.req_last & own_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.arb_en && found) begin
          state_nxt = ST_BURST;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        accept = own_valid & ~own_mask & ~bus.fifo_full;
        // A full FIFO only stalls; idle or masked owner ends the burst.
        if (!own_valid || own_mask) begin
          done = 1'b1;
        end else if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (own_last || cnt_nxt == cnt_t'(MAX_BURST))
            done = 1'b1;
        end
        if (done) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          rr_nxt    = (owner == id_t'(NREQ-1)) ? '0
                                               : owner + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && owner == id_t'(i))
        data_mux = bus.req_data[i*DW +: DW];
    end
  end

  assign bus.req_ready    = accept ? own_oh : '0;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_data_in = data_mux;
  assign bus.busy         = (state == ST_BURST);
  assign bus.grant_id     = (state == ST_BURST) ? owner : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus
// hand-written bursts for stall, mask, enable and reset cases.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  fifo_wr_arbiter #(
    .NREQ(4), .DW(8), .MAX_BURST(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [3:0]  m;
    logic        full;
    logic        en;
    logic [31:0] d;
    logic        busy;
    logic [2:0]  gid;
    logic        wr;
    logic [3:0]  rdy;
    logic [7:0]  dout;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic b,
                         input logic [2:0] g, input logic w,
                         input logic [3:0] r, input logic [7:0] d);
    chk({nm, ".busy"}, 32'(bus.busy), 32'(b));
    chk({nm, ".gid"}, 32'(bus.grant_id), 32'(g));
    chk({nm, ".wr"}, 32'(bus.fifo_wr_en), 32'(w));
    chk({nm, ".rdy"}, 32'(bus.req_ready), 32'(r));
    chk({nm, ".data"}, 32'(bus.fifo_data_in), 32'(d));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clr_in;
    bus.arb_en    = 1'b0;
    bus.req_mask  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    clr_in();
    rst = 1'b1;
    #3;
    chk_out(nm, 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
    step();
    rst = 1'b0;
  endtask

  // One idle arbitration cycle, then beats from requester g.
  // Requester i carries data 0x11*(i+1) (req_data=44332211).
  task automatic run_grant(input string nm, input int g,
                           input int beats);
    logic [7:0] e;
    e = 8'((g + 1) * 17);
    settle();
    chk_out({nm, ".arb"}, 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
    step();
    for (int b = 0; b < beats; b++) begin
      settle();
      chk_out({nm, ".beat"}, 1'b1, 3'(g), 1'b1,
              4'(1 << g), e);
      step();
    end
  endtask

  initial begin
    int writes;
    int seq[5];
    int mseq[3];

    tv[0] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1,
              32'h11, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h00};
    tv[1] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1,
              32'h11, 1'b1, 3'd0, 1'b1, 4'b0001, 8'h11};
    tv[2] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1,
              32'h12, 1'b1, 3'd0, 1'b1, 4'b0001, 8'h12};
    tv[3] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1,
              32'h13, 1'b1, 3'd0, 1'b1, 4'b0001, 8'h13};
    tv[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1,
              32'h0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h00};
    tv[5] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1,
              32'hA3A2A1A0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h00};
    tv[6] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1,
              32'hA3A2A1A0, 1'b1, 3'd1, 1'b1, 4'b0010, 8'hA1};
    tv[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1,
              32'h0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h00};

    seq  = '{0, 1, 2, 3, 0};
    mseq = '{0, 2, 3};

    // Single producer, then rr_ptr=1 shown by picking req 1.
    do_reset("t1.rst");
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = tv[i].v;
      bus.req_last  = tv[i].l;
      bus.req_mask  = tv[i].m;
      bus.fifo_full = tv[i].full;
      bus.arb_en    = tv[i].en;
      bus.req_data  = tv[i].d;
      settle();
      chk_out($sformatf("t1.v%0d", i), tv[i].busy, tv[i].gid,
              tv[i].wr, tv[i].rdy, tv[i].dout);
      step();
    end

    // All valid, never last: 4-beat bursts 0,1,2,3,0.
    do_reset("t2.rst");
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    bus.arb_en    = 1'b1;
    for (int i = 0; i < 5; i++)
      run_grant($sformatf("t2.g%0d", i), seq[i], 4);

    // Owner 2 stalled by a full FIFO for 5 cycles.
    do_reset("t3.rst");
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h44332211;
    bus.arb_en    = 1'b1;
    run_grant("t3.pre", 2, 2);
    writes = 2;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_out("t3.stall", 1'b1, 3'd2, 1'b0, 4'd0, 8'd0);
      writes += int'(bus.fifo_wr_en);
      step();
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_out("t3.resume", 1'b1, 3'd2, 1'b1, 4'b0100, 8'h33);
      writes += int'(bus.fifo_wr_en);
      step();
    end
    settle();
    chk("t3.writes", 32'(writes), 32'd4);
    chk("t3.idle", 32'(bus.busy), 32'd0);

    // Requester 1 masked; then owner 0 masked mid-burst.
    do_reset("t4.rst");
    bus.req_valid = 4'b1111;
    bus.req_mask  = 4'b0010;
    bus.req_data  = 32'h44332211;
    bus.arb_en    = 1'b1;
    for (int i = 0; i < 3; i++)
      run_grant($sformatf("t4.g%0d", i), mseq[i], 4);
    run_grant("t4.g3", 0, 2);
    bus.req_mask = 4'b0011;
    settle();
    chk_out("t4.mask", 1'b1, 3'd0, 1'b0, 4'd0, 8'd0);
    step();
    settle();
    chk_out("t4.exit", 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
    step();
    settle();
    chk_out("t4.next", 1'b1, 3'd2, 1'b1, 4'b0100, 8'h33);
    step();

    // arb_en low blocks grants; a started burst still finishes.
    do_reset("t5.rst");
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_out("t5.off", 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
      step();
    end
    bus.arb_en = 1'b1;
    settle();
    chk_out("t5.arb", 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
    step();
    bus.arb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_out("t5.beat", 1'b1, 3'd0, 1'b1, 4'b0001, 8'h11);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_out("t5.hold", 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
      step();
    end

    // Async reset mid-burst (owner 3, two beats done).
    do_reset("t6.rst");
    bus.req_valid = 4'b1000;
    bus.req_data  = 32'h44332211;
    bus.arb_en    = 1'b1;
    run_grant("t6.pre", 3, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("t6.async", 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
    bus.req_valid = 4'b1111;
    step();
    rst = 1'b0;
    run_grant("t6.post", 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
